// File: rtl/weight_loader_wq_weight_mmap_m_axi_srl.sv
// ---------------------------------------------------------------------------
// weight_loader_wq_weight_mmap_m_axi_srl
// Shift-register word storage for the weight-loader AXI FIFO. New words enter
// at entry 0 and everything else shifts up by one, so the oldest stored word
// always sits at entry (used-1). A read copies the addressed entry into the
// registered output; because both happen on the same edge with non-blocking
// updates, a simultaneous write and read returns the pre-shift (oldest) word.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears dout only)
//   clk_en      - global enable; low freezes storage and dout
//   we, din     - shift in din at entry 0
//   raddr, re   - copy entry raddr into dout
//   dout        - registered read data
// ---------------------------------------------------------------------------
module weight_loader_wq_weight_mmap_m_axi_srl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] dout
);

    // One word of the FIFO capacity lives in the output register, so the
    // shift storage holds DEPTH-1 words.
    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-2];
    logic [DATA_WIDTH-1:0] dout_q;

    // Storage is deliberately not reset: contents past used are don't-care.
    always_ff @(posedge clk) begin
        if (clk_en && we) begin
            mem_q[0] <= din;
            for (int i = 1; i < DEPTH - 1; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
        end else if (clk_en && re) begin
            dout_q <= mem_q[raddr];
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/weight_loader_wq_weight_mmap_m_axi_fifo.sv
// ---------------------------------------------------------------------------
// weight_loader_wq_weight_mmap_m_axi_fifo
// First-word-fall-through style FIFO built from a shift-register store plus
// one output register. Total capacity is DEPTH words: DEPTH-1 in the store
// and one presented on if_dout.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   clk_en          - global enable; low freezes all state
//   if_write/if_din - producer side; accepted when if_full_n is high
//   if_full_n       - high while the store has room
//   if_read         - consumer acknowledges the word on if_dout
//   if_dout         - head word, valid while if_empty_n is high
//   if_empty_n      - output register holds a valid word
//   num_data_valid  - words held in store plus output register
// ---------------------------------------------------------------------------
module weight_loader_wq_weight_mmap_m_axi_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   num_data_valid
);

    localparam logic [ADDR_WIDTH:0] USED_MAX = (ADDR_WIDTH+1)'(DEPTH - 1);

    logic [ADDR_WIDTH:0]   used_q, used_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  valid_q, valid_d;
    logic                  push, pop;

    // Full is judged on the current fill only; a same-cycle pop does not
    // open room for a write, which keeps if_full_n free of if_read paths.
    assign if_full_n = (used_q != USED_MAX);
    assign push      = clk_en & if_write & if_full_n;
    // Refill the output register whenever it is empty or being consumed.
    assign pop       = clk_en & (used_q != '0) & (~valid_q | if_read);

    always_comb begin
        used_d  = used_q + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};
        raddr_d = (used_d == '0) ? '0 : ADDR_WIDTH'(used_d - 1'b1);
        valid_d = valid_q;
        if (pop) begin
            valid_d = 1'b1;
        end else if (clk_en && if_read) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            used_q  <= '0;
            raddr_q <= '0;
            valid_q <= 1'b0;
        end else if (clk_en) begin
            used_q  <= used_d;
            raddr_q <= raddr_d;
            valid_q <= valid_d;
        end
    end

    weight_loader_wq_weight_mmap_m_axi_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .we     (push),
        .din    (if_din),
        .raddr  (raddr_q),
        .re     (pop),
        .dout   (if_dout)
    );

    assign if_empty_n     = valid_q;
    assign num_data_valid = used_q + {{ADDR_WIDTH{1'b0}}, valid_q};

endmodule

// File: doc/weight_loader_wq_weight_mmap_m_axi_fifo.md
WEIGHT_LOADER_WQ_WEIGHT_MMAP_M_AXI_FIFO -- requirements
Module: weight_loader_wq_weight_mmap_m_axi_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 Parameter ADDR_WIDTH, default 6, width of the storage read index.
REQ-003 Parameter DEPTH, default 63, total capacity in words (DEPTH-1 in shift storage plus 1 in output register); DEPTH >= 2.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 clk_en  in  1  global enable; low freezes all state.
REQ-008 if_write  in  1  producer write request.
REQ-009 if_din  in  DATA_WIDTH  write data.
REQ-010 if_full_n  out  1  high when a write is accepted this cycle.
REQ-011 if_read  in  1  consumer read request.
REQ-012 if_dout  out  DATA_WIDTH  head word; valid while if_empty_n high.
REQ-013 if_empty_n  out  1  high when if_dout holds a valid word.
REQ-014 num_data_valid  out  ADDR_WIDTH+1  total words held (storage + output register).

Function
REQ-015 push = clk_en & if_write & if_full_n; write when if_full_n low SHALL be ignored, no state change.
REQ-016 pop = clk_en & (used != 0) & (~if_empty_n | if_read); moves oldest stored word into output register.
REQ-017 used counter (0..DEPTH-1) SHALL update used <= used + push - pop; push and pop in same cycle leave used unchanged.
REQ-018 Storage read index SHALL equal used-1 (registered, held at 0 when used==0); read on pop uses pre-shift contents, so simultaneous push and pop return the oldest word.
REQ-019 if_full_n SHALL be (used != DEPTH-1), computed from current used only; no write accepted at full even when pop occurs same cycle.
REQ-020 Output-valid flag SHALL set on pop, clear on clk_en & if_read & ~pop; if_empty_n equals this flag.
REQ-021 if_read while if_empty_n low SHALL be ignored.
REQ-022 Latency: word written into empty FIFO SHALL appear on if_dout with if_empty_n high 2 cycles after the accepting edge.
REQ-023 num_data_valid SHALL equal used + output-valid flag, never exceeding DEPTH.
REQ-024 Order SHALL be strict FIFO; no word dropped or duplicated across any push/pop interleaving.
REQ-025 clk_en low SHALL hold used, index, output register, and flags unchanged regardless of if_write/if_read.

Reset
REQ-026 On reset: used=0, read index=0, output-valid=0, if_dout=0, if_empty_n=0, if_full_n=1, num_data_valid=0.
REQ-027 Reset SHALL take priority over clk_en, push and pop; reset mid-burst discards all stored words; shift storage contents need not be cleared.

Structure
REQ-028 Shift storage SHALL be one sub-module, weight_loader_wq_weight_mmap_m_axi_srl (ports clk, reset, clk_en, we, din, raddr, re, dout), driven with we=push, re=pop, raddr=read index; instantiated with DEPTH-1... DEPTH parameter passed unchanged.
REQ-029 No shared package; DATA_WIDTH/ADDR_WIDTH/DEPTH remain module parameters; ADDR_WIDTH SHALL satisfy 2**ADDR_WIDTH >= DEPTH-1.

Verification
REQ-030 Reset then write 0x11 one cycle, if_read low -> if_empty_n high 2 cycles later, if_dout=0x11, num_data_valid=1.
REQ-031 Write 63 words 0..62 with if_read low -> if_full_n low after 63rd accept, num_data_valid=63; 64th write ignored; then read all -> 0..62 in order, if_empty_n low after last.
REQ-032 At full (63 words), assert if_write and if_read same cycle -> read accepted, write rejected, num_data_valid=62, if_full_n high next cycle.
REQ-033 Streaming: if_write and if_read high every cycle with data 0x100+n -> after 2-cycle fill, one word out per cycle in order, num_data_valid stable at 1-2, no loss.
REQ-034 Hold clk_en low 5 cycles with if_write/if_read high at 10 words -> num_data_valid stays 10, if_dout unchanged.
REQ-035 Load 20 words, assert reset one cycle with if_write high -> next cycle num_data_valid=0, if_empty_n=0, if_full_n=1, if_dout=0.
